// File: rtl/pack_scheduler.sv
// Two-lane round-robin front end for a shared posit packing/rounding datapath.
// Each accepted request is issued for one cycle, then its result is held until the consumer takes it.
module pack_scheduler #(
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0]       req_pre_0,
    input  logic [67:0]      req_mant_0,
    input  logic [19:0]      req_exp_0,
    input  logic [3:0]       req_s_0,
    input  logic [TAG_W-1:0] req_tag_0,
    input  logic [1:0]       req_pre_1,
    input  logic [67:0]      req_mant_1,
    input  logic [19:0]      req_exp_1,
    input  logic [3:0]       req_s_1,
    input  logic [TAG_W-1:0] req_tag_1,
    output logic [1:0]       pk_in_pre,
    output logic [67:0]      pk_mant,
    output logic [19:0]      pk_exp,
    output logic [3:0]       pk_s,
    input  logic [31:0]      pk_out_r,
    output logic             res_valid,
    output logic [31:0]      res_data,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_src,
    output logic [1:0]       res_pre,
    input  logic             res_ready,
    output logic [15:0]      op_cnt
);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    state_e      state_q, state_d;
    logic        rr_q;
    logic        win;
    logic        gnt;
    logic        accept;
    logic [15:0] op_cnt_q;

    // Lane B wins when it is the only requester or when both request and rr points at it.
    always_comb begin
        win    = (state_q == StIdle) || ((state_q == StResp) && res_ready);
        gnt    = req_valid[1] & (~req_valid[0] | rr_q);
        accept = win & (|req_valid) & rst_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StIssue;
            StIssue: state_d = StResp;
            StResp:  if (res_ready) state_d = accept ? StIssue : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready = 2'b00;
        if (accept) begin
            req_ready = gnt ? 2'b10 : 2'b01;
        end
        res_valid = (state_q == StResp);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q      <= 1'b0;
            pk_in_pre <= '0;
            pk_mant   <= '0;
            pk_exp    <= '0;
            pk_s      <= '0;
            res_tag   <= '0;
            res_src   <= 1'b0;
            res_pre   <= '0;
        end else if (accept) begin
            rr_q      <= ~gnt;
            pk_in_pre <= gnt ? req_pre_1  : req_pre_0;
            pk_mant   <= gnt ? req_mant_1 : req_mant_0;
            pk_exp    <= gnt ? req_exp_1  : req_exp_0;
            pk_s      <= gnt ? req_s_1    : req_s_0;
            res_tag   <= gnt ? req_tag_1  : req_tag_0;
            res_src   <= gnt;
            res_pre   <= gnt ? req_pre_1  : req_pre_0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data <= '0;
            op_cnt_q <= '0;
        end else begin
            if (state_q == StIssue) begin
                res_data <= pk_out_r;
            end
            if (res_valid && res_ready && (op_cnt_q != 16'hFFFF)) begin
                op_cnt_q <= op_cnt_q + 16'd1;
            end
        end
    end

    assign op_cnt = op_cnt_q;

endmodule

// File: doc/pack_scheduler.md
PACK_SCHEDULER -- requirements
Module: pack_scheduler

Interface
REQ-001 The module SHALL have parameter TAG_W, default 4, width of the per-request tag returned with each result.
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The module SHALL have ports req_valid, input, 2, and req_ready, output, 2, the per-requester handshake; index 0 is lane A and index 1 is lane B.
REQ-005 The module SHALL have the following per-requester operand inputs, each suffixed _0 and _1: req_pre (2 bits, precision mode), req_mant (68 bits), req_exp (20 bits), req_s (4 bits, signs) and req_tag (TAG_W bits).
REQ-006 The module SHALL have outputs pk_in_pre (2), pk_mant (68), pk_exp (20) and pk_s (4), which drive the shared packing/rounding datapath.
REQ-007 The module SHALL have input pk_out_r, 32 bits, the combinational packed posit word returned by the datapath.
REQ-008 The module SHALL have outputs res_valid (1), res_data (32), res_tag (TAG_W), res_src (1, index of the granted requester) and res_pre (2), and input res_ready (1).
REQ-009 The module SHALL have output op_cnt, 16 bits, the count of completed results.

Function
REQ-010 The FSM SHALL have three states:
- IDLE: no operation in flight.
- ISSUE: operands are driven to the datapath.
- RESP: a result is held for the consumer.
REQ-011 An accept window SHALL exist when state==IDLE, or when state==RESP and res_ready==1.
REQ-012 req_ready[i] SHALL be 1 only when the accept window is open and requester i is granted; at most one bit SHALL be set per cycle.
REQ-013 Arbitration SHALL be round-robin:
- If only one requester is valid, it SHALL be granted.
- If both are valid, the requester indicated by pointer rr SHALL be granted.
- After any grant to i, rr SHALL become ~i.
REQ-014 On an accept, the pk_* registers SHALL load the granted operands, the tag/src/pre of the request SHALL be registered, and the state SHALL go to ISSUE.
REQ-015 ISSUE SHALL last exactly one cycle; at its end res_data SHALL capture pk_out_r and the state SHALL go to RESP.
REQ-016 In RESP, res_valid SHALL be 1, and res_data, res_tag, res_src and res_pre SHALL stay stable until res_ready==1.
REQ-017 In RESP with res_ready==1, the state SHALL go to ISSUE if a new accept occurs in the same cycle, otherwise to IDLE.
REQ-018 Latency SHALL be as follows:
- An accept at edge t gives res_valid at edge t+2.
- Sustained back-to-back throughput with res_ready held at 1 SHALL be one result every 2 cycles.
REQ-019 The pk_* outputs SHALL hold their last loaded values in IDLE and RESP, and SHALL change only on an accept.
REQ-020 req_pre==2'b11 SHALL be forwarded unchanged, with no error and no special handling.
REQ-021 op_cnt SHALL increment by 1 on each cycle where res_valid & res_ready, and SHALL saturate at 16'hFFFF.
REQ-022 When req_valid drops without a grant, no state SHALL change and the rr pointer SHALL be unchanged.

Reset
REQ-023 While rst_n==0, state SHALL be IDLE, rr SHALL be 0, and all outputs SHALL be 0: req_ready, pk_*, res_*, op_cnt.
REQ-024 An assertion of rst_n mid-operation (in ISSUE or RESP) SHALL discard the in-flight result, so that no res_valid pulse appears after release.
REQ-025 The first accept after reset release SHALL be accepted no earlier than the first clk edge at which rst_n==1.

Verification
REQ-026 Single op:
- Stimulus: req_valid=2'b01, req_pre_0=2'b10, req_tag_0=4'h3; the bench model returns pk_out_r=32'h4000_0000.
- Response: res_valid 2 cycles after the accept, res_data=32'h4000_0000, res_tag=3, res_src=0, res_pre=2'b10, op_cnt=1.
REQ-027 Contention:
- Stimulus: req_valid=2'b11 held for 4 results, res_ready=1.
- Response: res_src sequence 0,1,0,1; each result 2 cycles apart; op_cnt=4.
REQ-028 Backpressure:
- Stimulus: res_ready=0 for 5 cycles during RESP, with lane B valid.
- Response: res_data/res_tag stable; req_ready=0 throughout; lane B is accepted in the cycle res_ready rises.
REQ-029 Reset in flight:
- Stimulus: assert rst_n=0 during ISSUE.
- Response: all outputs 0 immediately; after release with no requests, res_valid stays 0 for 10 cycles.
REQ-030 Saturation:
- Stimulus: preload op_cnt via 65535 completions, then complete 2 more.
- Response: op_cnt=16'hFFFF.
